pr_free_list_banked: RTL
========================

Name: pr_free_list_banked

Overview:
Banked physical-register free list for rename. It is the parametrised successor to the fixed free-list constants.
- PRs are interleaved across banks by low PR bits.
- Each bank is a circular FIFO of free PR upper-index fields, with one dequeue port (rename) and one enqueue port (ROB PR-free queue).
- Per-bank occupancy and lower/upper threshold flags feed rename bank steering.

Parameters:
- PR_COUNT, 128, total physical registers; power of 2.
- BANK_COUNT, 4, free-list banks; power of 2, divides PR_COUNT.
- INIT_MAPPED_COUNT, 32, PRs mapped at reset (p0..p(N-1)); multiple of BANK_COUNT.
- LOWER_THRESHOLD, 8, low-occupancy flag threshold per bank.
- UPPER_THRESHOLD, 24, high-occupancy flag threshold per bank.
- Derived: LOG_PR_COUNT; LOG_BANK_COUNT; LEN=PR_COUNT/BANK_COUNT; LOG_LEN; IDXW=LOG_PR_COUNT-LOG_BANK_COUNT.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous reset, active-low.
- deq_valid  in  [BANK_COUNT]  rename requests one free PR from bank b.
- deq_ready  out  [BANK_COUNT]  bank b non-empty.
- deq_PR  out  [BANK_COUNT][LOG_PR_COUNT]  head PR of bank b; valid while deq_ready[b].
- enq_valid  in  [BANK_COUNT]  PR returned to bank b.
- enq_PR  in  [BANK_COUNT][LOG_PR_COUNT]  returned PR; low LOG_BANK_COUNT bits must equal b.
- free_count  out  [BANK_COUNT][LOG_LEN+1]  registered occupancy per bank.
- below_lower  out  [BANK_COUNT]  free_count[b] < LOWER_THRESHOLD.
- above_upper  out  [BANK_COUNT]  free_count[b] > UPPER_THRESHOLD.
- error  out  1  sticky: enq to full bank, or enq_PR bank bits != b.

Behaviour:
- Per-bank state:
  - LEN x IDXW entry array.
  - head and tail pointers, LOG_LEN bits each, wrap modulo LEN.
  - count register, LOG_LEN+1 bits.
- Reset (async, nRST=0), per bank:
  - M=INIT_MAPPED_COUNT/BANK_COUNT.
  - entry[i]=M+i for i<LEN-M; other entries 0.
  - head=0; tail=(LEN-M) mod LEN; count=LEN-M.
  - error=0.
- All outputs are combinational from registered state only, with no input-to-output paths:
  - deq_PR[b] = {entry[head], b[LOG_BANK_COUNT-1:0]}.
  - deq_ready[b] = (count!=0).
- Dequeue fires when deq_valid[b] && deq_ready[b]: head+1 next cycle. deq_valid with ready low is ignored and causes no error.
- Enqueue fires when enq_valid[b] && count!=LEN:
  - writes enq_PR[b][LOG_PR_COUNT-1:LOG_BANK_COUNT] at tail; tail+1.
  - Enqueue to a full bank is dropped and sets error.
  - Bank-bit mismatch still enqueues the upper bits and sets error.
- Simultaneous enq+deq in one bank: both fire, count unchanged.
- Enq to an empty bank: deq_ready rises the following cycle. No same-cycle bypass.
- When LEN==M... not permitted. Require INIT_MAPPED_COUNT < PR_COUNT.
- Banks are fully independent; any combination of ports may fire in one cycle.
- error clears only on reset.
- Reset mid-operation: all in-flight handshakes are discarded and the list reinitialises. Rename/ROB restart separately.

Decomposition:
- Shared package (core types):
  - PR_COUNT, FREE_LIST_BANK_COUNT, FREE_LIST_LENGTH_PER_BANK and their logs.
  - FREE_LIST_LOWER/UPPER_THRESHOLD.
  - New typedef pr_t = logic[LOG_PR_COUNT-1:0].
- One sub-module, free_list_bank:
  - single-bank circular FIFO with parameters LEN, IDXW, BANK_ID, INIT_M and the thresholds.
  - instantiated BANK_COUNT times via generate.
  - The top module ORs the per-bank error bits into the sticky flag.

Test Plan:
- Reset with defaults (all outputs are wires from state, no inputs needed) -> deq_ready=4'b1111; deq_PR = 32,33,34,35; free_count=24 each; below_lower=0; above_upper=0; error=0.
- Hold deq_valid[0]=1 for 24 cycles -> bank0 yields 32,36,...,124 in order; then deq_ready[0]=0 and free_count[0]=0. below_lower[0] rises once count<8, i.e. after the 17th dequeue. Other banks unchanged.
- From empty bank0: enq PR 4 then PR 8 on consecutive cycles -> deq_ready[0] rises the cycle after the first enq; deq_PR[0]=4 then 8; count=2.
- Bank1 at count 24: simultaneous enq PR 1 and deq for 10 cycles -> count stays 24; after 24 dequeues PR 1 appears (wrap-around of head/tail verified).
- Return mapped PRs 0,4,...,28 to bank0 from count 24 -> count=32, above_upper[0]=1. Then one extra enq -> dropped, error=1, count=32. Assert nRST -> error=0, count=24.
- enq_valid[2]=1 with enq_PR=5 (bank bits 01) -> error=1; free_count[2] increments by 1.

Source files
------------

// File: rtl/pr_free_list_banked_pkg.sv
// rtl/pr_free_list_banked_pkg.sv - shared rename free-list types and default sizing
package pr_free_list_banked_pkg;

   localparam int PR_COUNT                  = 128;
   localparam int LOG_PR_COUNT              = $clog2(PR_COUNT);
   localparam int FREE_LIST_BANK_COUNT      = 4;
   localparam int LOG_FREE_LIST_BANK_COUNT  = $clog2(FREE_LIST_BANK_COUNT);
   localparam int FREE_LIST_LENGTH_PER_BANK = PR_COUNT / FREE_LIST_BANK_COUNT;
   localparam int LOG_FREE_LIST_LENGTH_PER_BANK = $clog2(FREE_LIST_LENGTH_PER_BANK);
   localparam int INIT_MAPPED_COUNT         = 32;
   localparam int FREE_LIST_LOWER_THRESHOLD = 8;
   localparam int FREE_LIST_UPPER_THRESHOLD = 24;

   typedef logic [LOG_PR_COUNT-1:0] pr_t;

endpackage

// File: rtl/free_list_bank.sv
// rtl/free_list_bank.sv - one bank of the physical-register free list (circular FIFO)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   deq_valid / deq_ready  rename takes the head PR when both high
//   deq_pr                 head PR = {entry[head], BANK_ID}
//   enq_valid / enq_pr     PR returned by the ROB; upper bits stored at tail
//   free_count             registered occupancy
//   below_lower/above_upper occupancy threshold flags
//   error                  sticky: enqueue to full bank or bank-bit mismatch
module free_list_bank
   import pr_free_list_banked_pkg::*;
#(
   parameter int LEN             = 32,
   parameter int IDXW            = 5,
   parameter int LOG_BANK        = 2,
   parameter int BANK_ID         = 0,
   parameter int INIT_M          = 8,
   parameter int LOWER_THRESHOLD = 8,
   parameter int UPPER_THRESHOLD = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      deq_valid,
   output logic                      deq_ready,
   output logic [IDXW+LOG_BANK-1:0]  deq_pr,
   input  logic                      enq_valid,
   input  logic [IDXW+LOG_BANK-1:0]  enq_pr,
   output logic [$clog2(LEN):0]      free_count,
   output logic                      below_lower,
   output logic                      above_upper,
   output logic                      error
);

   localparam int LOG_LEN = $clog2(LEN);
   localparam int PRW     = IDXW + LOG_BANK;
   localparam int INIT_FREE = LEN - INIT_M;

   localparam logic [LOG_LEN:0]   FULL_C  = (LOG_LEN+1)'(LEN);
   localparam logic [LOG_LEN:0]   INIT_C  = (LOG_LEN+1)'(INIT_FREE);
   localparam logic [LOG_LEN:0]   LOW_C   = (LOG_LEN+1)'(LOWER_THRESHOLD);
   localparam logic [LOG_LEN:0]   HIGH_C  = (LOG_LEN+1)'(UPPER_THRESHOLD);
   localparam logic [LOG_LEN-1:0] TAIL0_C = LOG_LEN'(INIT_FREE % LEN);
   localparam logic [LOG_BANK-1:0] BANK_C = LOG_BANK'(BANK_ID);

   logic [IDXW-1:0]    entry [LEN];
   logic [LOG_LEN-1:0] head;
   logic [LOG_LEN-1:0] tail;
   logic [LOG_LEN:0]   count;
   logic               err_q;

   logic deq_fire;
   logic enq_fire;
   logic enq_full;
   logic enq_mismatch;

   assign deq_fire     = deq_valid && (count != '0);
   assign enq_full     = enq_valid && (count == FULL_C);
   assign enq_fire     = enq_valid && (count != FULL_C);
   // A mis-banked PR is still stored (upper bits only) but flagged.
   assign enq_mismatch = enq_valid && (enq_pr[LOG_BANK-1:0] != BANK_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // PRs p0..p(INIT_MAPPED-1) are mapped, so the free list starts at index INIT_M.
         for (int i = 0; i < LEN; i++) begin
            if (i < INIT_FREE) begin
               entry[i] <= IDXW'(INIT_M + i);
            end else begin
               entry[i] <= '0;
            end
         end
      end else if (enq_fire) begin
         entry[tail] <= enq_pr[PRW-1:LOG_BANK];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= TAIL0_C;
         count <= INIT_C;
         err_q <= 1'b0;
      end else begin
         if (deq_fire) begin
            head <= head + 1'b1;
         end
         if (enq_fire) begin
            tail <= tail + 1'b1;
         end
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (enq_full || enq_mismatch) begin
            err_q <= 1'b1;
         end
      end
   end

   assign deq_ready   = (count != '0);
   assign deq_pr      = {entry[head], BANK_C};
   assign free_count  = count;
   assign below_lower = (count < LOW_C);
   assign above_upper = (count > HIGH_C);
   assign error       = err_q;

endmodule

// File: rtl/pr_free_list_banked.sv
// rtl/pr_free_list_banked.sv - banked physical-register free list for rename
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   deq_valid/deq_ready/deq_PR   per-bank dequeue to rename
//   enq_valid/enq_PR             per-bank return of freed PRs from the ROB
//   free_count                   per-bank occupancy
//   below_lower/above_upper      per-bank threshold flags for bank steering
//   error                        sticky OR of all bank errors
// INIT_MAPPED_COUNT must be below PR_COUNT and a multiple of BANK_COUNT.
module pr_free_list_banked
   import pr_free_list_banked_pkg::*;
#(
   parameter int PR_COUNT          = pr_free_list_banked_pkg::PR_COUNT,
   parameter int BANK_COUNT        = pr_free_list_banked_pkg::FREE_LIST_BANK_COUNT,
   parameter int INIT_MAPPED_COUNT = pr_free_list_banked_pkg::INIT_MAPPED_COUNT,
   parameter int LOWER_THRESHOLD   = pr_free_list_banked_pkg::FREE_LIST_LOWER_THRESHOLD,
   parameter int UPPER_THRESHOLD   = pr_free_list_banked_pkg::FREE_LIST_UPPER_THRESHOLD
) (
   input  logic                                                  CLK,
   input  logic                                                  nRST,
   input  logic [BANK_COUNT-1:0]                                 deq_valid,
   output logic [BANK_COUNT-1:0]                                 deq_ready,
   output logic [BANK_COUNT-1:0][$clog2(PR_COUNT)-1:0]           deq_PR,
   input  logic [BANK_COUNT-1:0]                                 enq_valid,
   input  logic [BANK_COUNT-1:0][$clog2(PR_COUNT)-1:0]           enq_PR,
   output logic [BANK_COUNT-1:0][$clog2(PR_COUNT/BANK_COUNT):0]  free_count,
   output logic [BANK_COUNT-1:0]                                 below_lower,
   output logic [BANK_COUNT-1:0]                                 above_upper,
   output logic                                                  error
);

   localparam int LOG_PR_COUNT   = $clog2(PR_COUNT);
   localparam int LOG_BANK_COUNT = $clog2(BANK_COUNT);
   localparam int LEN            = PR_COUNT / BANK_COUNT;
   localparam int IDXW           = LOG_PR_COUNT - LOG_BANK_COUNT;
   localparam int INIT_M         = INIT_MAPPED_COUNT / BANK_COUNT;

   logic [BANK_COUNT-1:0] bank_error;

   for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      free_list_bank #(
         .LEN             (LEN),
         .IDXW            (IDXW),
         .LOG_BANK        (LOG_BANK_COUNT),
         .BANK_ID         (b),
         .INIT_M          (INIT_M),
         .LOWER_THRESHOLD (LOWER_THRESHOLD),
         .UPPER_THRESHOLD (UPPER_THRESHOLD)
      ) u_bank (
         .clk         (CLK),
         .rst_n       (nRST),
         .deq_valid   (deq_valid[b]),
         .deq_ready   (deq_ready[b]),
         .deq_pr      (deq_PR[b]),
         .enq_valid   (enq_valid[b]),
         .enq_pr      (enq_PR[b]),
         .free_count  (free_count[b]),
         .below_lower (below_lower[b]),
         .above_upper (above_upper[b]),
         .error       (bank_error[b])
      );
   end

   // Each bank's flag is already sticky, so the OR is sticky too.
   assign error = |bank_error;

endmodule
